invn_sweep_ctrl: RTL and testbench

Self-test sequencer for the N-bit selective inverter datapath (Y = X ^ MASK). It drives every input code 0..2^N-1 onto the datapath and waits a programmable settle time. It then samples the output, compares it against X ^ MASK, and reports the pass/fail result, the failure count and the first failing code through a start/busy/done handshake. It sits between the system control logic and one inverter instance, replacing bench-only checking with an in-silicon sweep.

---
 rtl/invn_sweep_pkg.sv | 31 +++
 rtl/sweep_settle_timer.sv | 50 +++++
 rtl/invn_sweep_ctrl.sv | 165 ++++++++++++++++
 tb/tb_invn_sweep_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/invn_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : invn_sweep_pkg
//  Description : Shared types and helpers for the selective-inverter sweep
//                controller: FSM state encoding, default inversion mask and
//                the reference function for the expected datapath output.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package invn_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } sweep_state_e;

    localparam logic [3:0] MASK_DEFAULT = 4'b0101;

    // Fixed operand width so a single function serves every datapath width
    // up to 32 bits; callers zero-extend their operands into it.
    localparam int EXP_W = 32;

    function automatic logic [EXP_W-1:0] expected_y(input logic [EXP_W-1:0] x,
                                                    input logic [EXP_W-1:0] mask);
        return x ^ mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_settle_timer
//  Description : Loadable down-counter with zero flag. A load sets the count
//                to SETTLE-1 so that, counting the load cycle's successor,
//                the flag rises after exactly SETTLE cycles of holding.
//  Ports       : clk     - rising-edge clock
//                reset   - synchronous active-high reset (count -> 0)
//                load_i  - reload count with SETTLE-1 (has priority)
//                dec_i   - decrement by one when non-zero
//                zero_o  - count is zero
//  Revision    : 1.0  initial release
// ============================================================================
module sweep_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/invn_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : invn_sweep_ctrl
//  Description : In-silicon self-test sequencer for an N-bit selective
//                inverter (Y = X ^ MASK). Sweeps every code, holds each for
//                SETTLE cycles, samples Y, counts mismatches and records the
//                first failing code. Start/busy/done handshake.
//  Config      : INVN_SWEEP_STOPFAIL_EN - when defined, the first mismatch
//                ends the sweep immediately (x_out holds the failing code).
//  Ports       : clk          - rising-edge clock
//                reset        - synchronous active-high reset
//                start        - request, accepted only while idle
//                x_out        - code driven to datapath X
//                y_in         - datapath Y
//                busy         - sweep in progress (through DONE)
//                done         - one-cycle completion pulse
//                pass         - last sweep had no mismatches
//                fail_count   - mismatching codes (N+1 bits, max 2^N)
//                first_fail_x - first mismatching code (valid if count != 0)
//  Revision    : 1.0  initial release
// ============================================================================
module invn_sweep_ctrl
    import invn_sweep_pkg::*;
#(
    parameter int           N      = 4,
    parameter logic [N-1:0] MASK   = N'(MASK_DEFAULT),
    parameter int           SETTLE = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [N-1:0] x_out,
    input  logic [N-1:0] y_in,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   fail_count,
    output logic [N-1:0] first_fail_x
);

    localparam logic [N-1:0] X_LAST = '1;

    sweep_state_e state_q, state_d;
    logic [N-1:0] x_q, x_d;
    logic [N:0]   fail_q, fail_d;
    logic [N-1:0] first_q, first_d;
    logic         pass_q, pass_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic             w_tmr_load;
    logic             w_tmr_dec;
    logic             w_tmr_zero;
    logic [EXP_W-1:0] w_exp_y;
    logic             w_mismatch;

    sweep_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (w_tmr_load),
        .dec_i  (w_tmr_dec),
        .zero_o (w_tmr_zero)
    );

    assign w_exp_y    = expected_y(EXP_W'(x_q), EXP_W'(MASK));
    assign w_mismatch = (EXP_W'(y_in) != w_exp_y);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        fail_d     = fail_q;
        first_d    = first_q;
        pass_d     = pass_q;
        w_tmr_load = 1'b0;
        w_tmr_dec  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d        = '0;
                    fail_d     = '0;
                    pass_d     = 1'b0;
                    w_tmr_load = 1'b1;
                    state_d    = S_APPLY;
                end
            end
            S_APPLY: begin
                if (w_tmr_zero) begin
                    state_d = S_CHECK;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    fail_d = fail_q + 1'b1;
                    if (fail_q == '0) begin
                        first_d = x_q;
                    end
                end
`ifdef INVN_SWEEP_STOPFAIL_EN
                if (w_mismatch || (x_q == X_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    x_d        = x_q + 1'b1;
                    w_tmr_load = 1'b1;
                    state_d    = S_APPLY;
                end
`else
                // Terminal code is tested before increment so x_out never wraps.
                if (x_q == X_LAST) begin
                    state_d = S_DONE;
                end else begin
                    x_d        = x_q + 1'b1;
                    w_tmr_load = 1'b1;
                    state_d    = S_APPLY;
                end
`endif
            end
            S_DONE: begin
                pass_d  = (fail_q == '0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // busy/done are decoded from the next state so both land registered in
    // the same cycle the FSM enters the corresponding state.
    assign busy_d = (state_d != S_IDLE);
    assign done_d = (state_d == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            fail_q  <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            fail_q  <= fail_d;
            first_q <= first_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x_out        = x_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail_count   = fail_q;
    assign first_fail_x = first_q;

endmodule
`default_nettype wire

// File: tb/tb_invn_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_invn_sweep_ctrl
//  Description : Directed self-checking bench for invn_sweep_ctrl with a
//                behavioural inverter model (healthy or with planted faults)
//                and a queue of expected sweep results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_invn_sweep_ctrl;

    localparam logic [3:0] MASK_REF = 4'b0101;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] x_out;
    logic [3:0] y_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] fail_count;
    logic [3:0] first_fail_x;

    int mode;      // 0 healthy, 1 y[0] stuck at 0, 2 wrong output at x=3
    int n;         // cycle index relative to the start edge (cycle 0)
    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        int         done_cyc;
        logic [4:0] fc;
        logic [3:0] ff;
        logic [3:0] xo;
        logic       pass;
    } exp_t;

    exp_t sb[$];

    invn_sweep_ctrl #(
        .N      (4),
        .MASK   (MASK_REF),
        .SETTLE (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .x_out        (x_out),
        .y_in         (y_in),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_count   (fail_count),
        .first_fail_x (first_fail_x)
    );

    always #5 clk = ~clk;

    // Inverter datapath model.
    always_comb begin
        y_in = x_out ^ MASK_REF;
        if (mode == 1) begin
            y_in[0] = 1'b0;
        end else if ((mode == 2) && (x_out == 4'd3)) begin
            y_in = 4'b1111;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x_out"},  32'(x_out),        32'd0);
        chk({tag, "_busy"},   32'(busy),         32'd0);
        chk({tag, "_done"},   32'(done),         32'd0);
        chk({tag, "_pass"},   32'(pass),         32'd0);
        chk({tag, "_fcnt"},   32'(fail_count),   32'd0);
        chk({tag, "_first"},  32'(first_fail_x), 32'd0);
    endtask

    // Expected outcome per datapath mode (hand-derived from Y = X ^ 0101).
    function automatic exp_t expect_for(input string tag, input int m);
        exp_t e;
        e.tag = tag;
`ifdef INVN_SWEEP_STOPFAIL_EN
        case (m)
            1:       begin e.done_cyc = 4;  e.fc = 5'd1; e.ff = 4'd0; e.xo = 4'd0;  e.pass = 1'b0; end
            2:       begin e.done_cyc = 13; e.fc = 5'd1; e.ff = 4'd3; e.xo = 4'd3;  e.pass = 1'b0; end
            default: begin e.done_cyc = 49; e.fc = 5'd0; e.ff = 4'd0; e.xo = 4'd15; e.pass = 1'b1; end
        endcase
`else
        case (m)
            1:       begin e.done_cyc = 49; e.fc = 5'd8; e.ff = 4'd0; e.xo = 4'd15; e.pass = 1'b0; end
            2:       begin e.done_cyc = 49; e.fc = 5'd1; e.ff = 4'd3; e.xo = 4'd15; e.pass = 1'b0; end
            default: begin e.done_cyc = 49; e.fc = 5'd0; e.ff = 4'd0; e.xo = 4'd15; e.pass = 1'b1; end
        endcase
`endif
        return e;
    endfunction

    // Drives a start pulse in the current cycle; on return we are in cycle 1.
    task automatic start_sweep(input string tag, input int m, input bit push);
        mode = m;
        if (push) sb.push_back(expect_for(tag, m));
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        chk({tag, "_busy_c1"}, 32'(busy),  32'd1);
        chk({tag, "_x_c1"},    32'(x_out), 32'd0);
    endtask

    // Waits (bounded) for done, optionally re-pulsing start at cycles 5 and 30,
    // then compares against the oldest queued expectation. Returns in the
    // cycle after DONE.
    task automatic wait_done(input bit repulse);
        exp_t e;
        while ((done !== 1'b1) && (n < 200)) begin
            start = repulse && ((n == 5) || (n == 30));
            tick();
            n++;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({e.tag, "_done_cycle"}, 32'(n),          32'(e.done_cyc));
        chk({e.tag, "_fcnt"},       32'(fail_count), 32'(e.fc));
        chk({e.tag, "_x_at_done"},  32'(x_out),      32'(e.xo));
        if (e.fc != 5'd0) chk({e.tag, "_first"}, 32'(first_fail_x), 32'(e.ff));
        tick();
        chk({e.tag, "_done_pulse_end"}, 32'(done), 32'd0);
        chk({e.tag, "_busy_after"},     32'(busy), 32'd0);
        chk({e.tag, "_pass"},           32'(pass), 32'(e.pass));
    endtask

    initial begin
        mode  = 0;
        n     = 0;
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        start_sweep("healthy", 0, 1'b1);
        wait_done(1'b0);

        start_sweep("stuck0", 1, 1'b1);
        wait_done(1'b0);

        start_sweep("fault_x3", 2, 1'b1);
        wait_done(1'b0);

        start_sweep("repulse", 0, 1'b1);
        wait_done(1'b1);
        tick();
        tick();
        chk("repulse_no_queued_done", 32'(done), 32'd0);
        chk("repulse_no_queued_busy", 32'(busy), 32'd0);

        // Leave a non-zero fail_count/first_fail_x so reset has work to do.
        start_sweep("fault_pre", 1, 1'b1);
        wait_done(1'b0);
        start_sweep("abort", 1, 1'b0);
        while (n < 20) begin
            tick();
            n++;
        end
        chk("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("abort");
        tick();
        start_sweep("after_reset", 0, 1'b1);
        wait_done(1'b0);

        // Back-to-back: second start in the cycle right after DONE.
        start_sweep("b2b_first", 0, 1'b1);
        wait_done(1'b0);
        start_sweep("b2b_second", 2, 1'b1);
        chk("b2b_pass_cleared", 32'(pass), 32'd0);
        wait_done(1'b0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
